sram_like_data_slave: RTL and testbench

- Responder end of the CPU data-memory interface: accepts byte-strobed load/store requests (addr, size, 4-bit byte select, lane-replicated write data) from the memory-stage select logic.
- Stores data in an internal word array and returns full 32-bit words after a programmable latency. The master extracts bytes and halves.
- Used as the data-RAM model behind the SRAM-like port in simulation and FPGA builds. Also checks that size and byte select are consistent with each other.

---
 rtl/sram_like_data_slave.sv | 147 ++++++++++++++
 tb/tb_sram_like_data_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_data_slave.sv
// sram_like_data_slave
// Responder end of the CPU data-memory SRAM-like port. Accepts one byte-strobed
// load/store at a time, commits stores at the acceptance edge, and returns the
// full 32-bit word (plus a size/strobe legality flag) LATENCY cycles later.
module sram_like_data_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  // With a one-cycle latency the response is produced straight from the
  // acceptance edge, so the countdown is bypassed.
  localparam logic       LAT_ONE  = (LATENCY == 1);

  // Size/strobe consistency: 1 when the combination is illegal.
  function automatic logic f_size_strobe_illegal(input logic [1:0] sz,
                                                 input logic [3:0] st);
    logic bad;
    case (sz)
      2'b00:   bad = !((st == 4'b0001) || (st == 4'b0010) ||
                       (st == 4'b0100) || (st == 4'b1000));
      2'b01:   bad = !((st == 4'b0011) || (st == 4'b1100));
      2'b10:   bad = (st != 4'b1111);
      default: bad = 1'b1;
    endcase
    return bad || (st == 4'b0000);
  endfunction

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_addr_ok;
  logic                r_data_ok;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic                r_wr;
  logic                r_err_chk;
  logic [31:0]         r_rword;
  logic [31:0]         r_mem [0:DEPTH-1];

  logic                w_accept;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_err_chk;
  logic                w_wr_en;
  logic                w_unused_addr;

  assign w_accept  = req & r_addr_ok;
  // Upper address bits are dropped so accesses wrap modulo the depth; the
  // byte offset is carried by wstrb, not by addr[1:0].
  assign w_idx     = addr[ADDR_W+1:2];
  assign w_err_chk = f_size_strobe_illegal(size, wstrb);
  assign w_wr_en   = w_accept & wr & ~w_err_chk;
  assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  assign addr_ok = r_addr_ok;
  assign data_ok = r_data_ok;
  assign rdata   = r_rdata;
  assign err     = r_err;

  // Word array: byte-lane writes and pre-write read capture at acceptance (not reset).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rword <= r_mem[w_idx];
    end
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en && wstrb[i]) begin
        r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Request/response FSM: acceptance, latency countdown and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_addr_ok <= 1'b0;
      r_data_ok <= 1'b0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
      r_wr      <= 1'b0;
      r_err_chk <= 1'b0;
    end else if (w_accept) begin
      // Accepted from IDLE or from the data_ok cycle of the previous request.
      r_state   <= ST_BUSY;
      r_cnt     <= CNT_INIT;
      r_wr      <= wr;
      r_err_chk <= w_err_chk;
      r_addr_ok <= LAT_ONE;
      r_data_ok <= LAT_ONE;
      r_err     <= LAT_ONE & w_err_chk;
      if (LAT_ONE && !wr) begin
        r_rdata <= r_mem[w_idx];
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_addr_ok <= 1'b1;
          r_data_ok <= 1'b0;
          r_err     <= 1'b0;
        end
        ST_BUSY: begin
          if (r_data_ok) begin
            // Response delivered and nothing new accepted: back to IDLE.
            r_state   <= ST_IDLE;
            r_addr_ok <= 1'b1;
            r_data_ok <= 1'b0;
            r_err     <= 1'b0;
          end else begin
            r_cnt     <= r_cnt - 4'd1;
            r_addr_ok <= (r_cnt == 4'd1);
            r_data_ok <= (r_cnt == 4'd1);
            r_err     <= (r_cnt == 4'd1) & r_err_chk;
            if ((r_cnt == 4'd1) && !r_wr) begin
              r_rdata <= r_rword;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_addr_ok <= 1'b0;
          r_data_ok <= 1'b0;
          r_err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Self-checking bench for sram_like_data_slave: a LATENCY=2 instance for the
// general scenarios and a LATENCY=1 instance for full-throughput streaming.
module tb_sram_like_data_slave;

  logic        clk;
  logic        resetn;
  logic        req1, req2;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok1, data_ok1, err1;
  logic        addr_ok2, data_ok2, err2;
  logic [31:0] rdata1, rdata2;

  int n_checks = 0;
  int n_pass   = 0;

  sram_like_data_slave #(.ADDR_W(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .req(req2), .wr(wr), .size(size),
    .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok2), .data_ok(data_ok2), .rdata(rdata2), .err(err2)
  );

  sram_like_data_slave #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .req(req1), .wr(wr), .size(size),
    .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request on the selected instance. lat = number of falling edges after
  // the acceptance edge up to and including the data_ok cycle (99 = timeout).
  // tail_ok = data_ok and err both low in the cycle after the pulse.
  task automatic xact(input bit sel1, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [3:0] st,
                      input logic [31:0] d, output int lat,
                      output logic [31:0] rd, output logic e,
                      output logic tail_ok);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (sel1 ? addr_ok1 : addr_ok2) break;
      @(negedge clk);
    end
    wr = w; size = sz; addr = a; wstrb = st; wdata = d;
    if (sel1) req1 = 1'b1; else req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0; req2 = 1'b0;
    // Scramble the request fields: they must not matter once accepted.
    addr = ~a; wdata = ~d; wr = ~w; wstrb = ~st;
    lat = 99; rd = 32'hx; e = 1'bx;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      if (sel1 ? data_ok1 : data_ok2) begin
        lat = k;
        rd  = sel1 ? rdata1 : rdata2;
        e   = sel1 ? err1 : err2;
        break;
      end
    end
    @(negedge clk);
    tail_ok = sel1 ? (!data_ok1 && !err1) : (!data_ok2 && !err2);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req1 = 1'b0; req2 = 1'b0; wr = 1'b0; size = 2'b10;
    addr = 32'd0; wstrb = 4'b1111; wdata = 32'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({addr_ok2, data_ok2, err2, rdata2} !== 35'd0) begin
      $display("FAIL reset_outputs: got ok=%b dok=%b err=%b rdata=%h, want all 0",
               addr_ok2, data_ok2, err2, rdata2);
    end else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({addr_ok2, addr_ok1} !== 2'b11) begin
      $display("FAIL reset_idle_addr_ok: got %b, want 11", {addr_ok2, addr_ok1});
    end else n_pass++;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic e, t;
    xact(1'b0, 1'b1, 2'b10, 32'h100, 4'b1111, 32'hDEADBEEF, lat, rd, e, t);
    n_checks++;
    if ({lat, e, t} !== {32'd2, 1'b0, 1'b1}) begin
      $display("FAIL sw_timing: got lat=%0d err=%b tail=%b, want lat=2 err=0 tail=1", lat, e, t);
    end else n_pass++;
    n_checks++;
    if (rd !== 32'd0) begin
      $display("FAIL sw_rdata_held: got %h, want 00000000", rd);
    end else n_pass++;
    xact(1'b0, 1'b0, 2'b10, 32'h100, 4'b1111, 32'h0, lat, rd, e, t);
    n_checks++;
    if ({lat, e, t, rd} !== {32'd2, 1'b0, 1'b1, 32'hDEADBEEF}) begin
      $display("FAIL lw_word: got lat=%0d err=%b tail=%b rdata=%h, want 2 0 1 deadbeef",
               lat, e, t, rd);
    end else n_pass++;
  endtask

  task automatic test_byte_store();
    int lat; logic [31:0] rd; logic e, t;
    xact(1'b0, 1'b1, 2'b10, 32'h100, 4'b1111, 32'h11223344, lat, rd, e, t);
    xact(1'b0, 1'b1, 2'b00, 32'h101, 4'b0010, 32'h5A5A5A5A, lat, rd, e, t);
    n_checks++;
    if ({lat, e} !== {32'd2, 1'b0}) begin
      $display("FAIL sb_resp: got lat=%0d err=%b, want 2 0", lat, e);
    end else n_pass++;
    xact(1'b0, 1'b0, 2'b10, 32'h100, 4'b1111, 32'h0, lat, rd, e, t);
    n_checks++;
    if (rd !== 32'h11225A44) begin
      $display("FAIL sb_merge: got %h, want 11225a44", rd);
    end else n_pass++;
  endtask

  logic [1:0] ill_sz  [0:5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [3:0] ill_st  [0:5] = '{4'b0011, 4'b0110, 4'b1100, 4'b0000, 4'b1111, 4'b1000};
  logic       ill_exp [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic test_illegal();
    int lat; logic [31:0] rd; logic e, t;
    xact(1'b0, 1'b1, 2'b10, 32'h100, 4'b0011, 32'hFFFFFFFF, lat, rd, e, t);
    n_checks++;
    if ({lat, e, t} !== {32'd2, 1'b1, 1'b1}) begin
      $display("FAIL ill_store_err: got lat=%0d err=%b tail=%b, want 2 1 1", lat, e, t);
    end else n_pass++;
    xact(1'b0, 1'b0, 2'b10, 32'h100, 4'b1111, 32'h0, lat, rd, e, t);
    n_checks++;
    if ({rd, e} !== {32'h11225A44, 1'b0}) begin
      $display("FAIL ill_store_nowrite: got %h err=%b, want 11225a44 0", rd, e);
    end else n_pass++;
    xact(1'b0, 1'b0, 2'b11, 32'h100, 4'b0011, 32'h0, lat, rd, e, t);
    n_checks++;
    if ({rd, e, t} !== {32'h11225A44, 1'b1, 1'b1}) begin
      $display("FAIL ill_load_size11: got %h err=%b tail=%b, want 11225a44 1 1", rd, e, t);
    end else n_pass++;
    for (int i = 0; i < 6; i++) begin
      xact(1'b0, 1'b0, ill_sz[i], 32'h100, ill_st[i], 32'h0, lat, rd, e, t);
      n_checks++;
      if ({e, rd} !== {ill_exp[i], 32'h11225A44}) begin
        $display("FAIL legality_%0d: size=%b wstrb=%b got err=%b rdata=%h, want err=%b rdata=11225a44",
                 i, ill_sz[i], ill_st[i], e, rd, ill_exp[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic e, t;
    xact(1'b0, 1'b1, 2'b10, 32'h1000, 4'b1111, 32'hCAFEF00D, lat, rd, e, t);
    xact(1'b0, 1'b0, 2'b10, 32'h0000, 4'b1111, 32'h0, lat, rd, e, t);
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin
      $display("FAIL wrap_alias: got %h, want cafef00d", rd);
    end else n_pass++;
    xact(1'b0, 1'b0, 2'b00, 32'h0003, 4'b1000, 32'h0, lat, rd, e, t);
    n_checks++;
    if ({rd, e} !== {32'hCAFEF00D, 1'b0}) begin
      $display("FAIL offset_ignored: got %h err=%b, want cafef00d 0", rd, e);
    end else n_pass++;
  endtask

  logic [31:0] b2b_data [0:3] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic e, t;
    logic [7:0] pat;
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 1'b1, 2'b10, 32'h40 + 32'(4*i), 4'b1111, b2b_data[i], lat, rd, e, t);
      n_checks++;
      if (lat !== 1) begin
        $display("FAIL lat1_store_%0d: got lat=%0d, want 1", i, lat);
      end else n_pass++;
    end
    @(negedge clk);
    wr = 1'b0; size = 2'b10; wstrb = 4'b1111; addr = 32'h40; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({addr_ok1, data_ok1, err1, rdata1} !== {1'b1, 1'b1, 1'b0, b2b_data[i]}) begin
        $display("FAIL b2b_lat1_%0d: got ok=%b dok=%b err=%b rdata=%h, want 1 1 0 %h",
                 i, addr_ok1, data_ok1, err1, rdata1, b2b_data[i]);
      end else n_pass++;
      if (i == 3) req1 = 1'b0;
      else addr = 32'h40 + 32'(4*(i+1));
    end
    @(negedge clk);
    n_checks++;
    if (data_ok1 !== 1'b0) begin
      $display("FAIL b2b_lat1_end: got dok=%b, want 0", data_ok1);
    end else n_pass++;
    // LATENCY=2 with req held: one acceptance every two cycles, no IDLE gap.
    wr = 1'b0; addr = 32'h100; req2 = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[i] = data_ok2;
      n_checks++;
      if (addr_ok2 !== data_ok2) begin
        $display("FAIL b2b_lat2_addr_ok_%0d: got ok=%b, want %b", i, addr_ok2, data_ok2);
      end else n_pass++;
    end
    req2 = 1'b0;
    n_checks++;
    if (pat !== 8'b10101010) begin
      $display("FAIL b2b_lat2_pattern: got %b, want 10101010", pat);
    end else n_pass++;
    @(negedge clk);
  endtask

  // Accept one request on the LATENCY=2 instance, pull reset low one cycle later.
  task automatic reset_after_accept(input logic w, input logic [31:0] a,
                                    input logic [31:0] d, output int pulses);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (addr_ok2) break;
      @(negedge clk);
    end
    wr = w; size = 2'b10; addr = a; wstrb = 4'b1111; wdata = d; req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req2 = 1'b0;
    resetn = 1'b0;
    pulses = 0;
    #1 if (data_ok2) pulses++;
    @(negedge clk);
    if (data_ok2) pulses++;
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (data_ok2) pulses++;
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses; logic [31:0] rd; logic e, t;
    reset_after_accept(1'b0, 32'h100, 32'h0, pulses);
    n_checks++;
    if (pulses !== 0) begin
      $display("FAIL rst_mid_load_no_resp: got %0d data_ok pulses, want 0", pulses);
    end else n_pass++;
    n_checks++;
    if (addr_ok2 !== 1'b1) begin
      $display("FAIL rst_mid_addr_ok: got %b, want 1", addr_ok2);
    end else n_pass++;
    xact(1'b0, 1'b0, 2'b10, 32'h100, 4'b1111, 32'h0, lat, rd, e, t);
    n_checks++;
    if ({lat, rd, e} !== {32'd2, 32'h11225A44, 1'b0}) begin
      $display("FAIL rst_mid_recover: got lat=%0d rdata=%h err=%b, want 2 11225a44 0", lat, rd, e);
    end else n_pass++;
    reset_after_accept(1'b1, 32'h200, 32'h0BADF00D, pulses);
    n_checks++;
    if (pulses !== 0) begin
      $display("FAIL rst_mid_store_no_resp: got %0d data_ok pulses, want 0", pulses);
    end else n_pass++;
    xact(1'b0, 1'b0, 2'b10, 32'h200, 4'b1111, 32'h0, lat, rd, e, t);
    n_checks++;
    if (rd !== 32'h0BADF00D) begin
      $display("FAIL rst_mid_store_kept: got %h, want 0badf00d", rd);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_store();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
